// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// uart_tx_feeder: buffers 24-bit event words and hands them to a send-only
// UART one at a time, injecting a tagged marker word after overflow drops.
// Revision: 1.0
// ============================================================================
module uart_tx_feeder #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] MARKER_TAG = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [23:0]           in_data,
  input  logic                  tx_empty,
  output logic                  transmit,
  output logic [23:0]           tx_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow_seen,
  output logic [15:0]           drop_count
);

  localparam logic [DEPTH_LOG2:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [23:0]           r_mem [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [15:0]           r_drop_count;
  logic                  r_overflow_seen;
  logic                  r_transmit;
  logic [23:0]           r_tx_data;

  logic                  w_pop;
  logic                  w_full_after;
  logic                  w_marker;
  logic                  w_push;
  logic                  w_drop;
  logic [23:0]           w_wdata;

  // A pop this cycle frees a slot, so the write side sees the post-read level.
  assign w_pop        = (r_state == ST_IDLE) && (r_level != '0) && tx_empty;
  assign w_full_after = (r_level == c_depth) && !w_pop;
  assign w_marker     = !w_full_after && (r_drop_count != 16'h0000);
  assign w_push       = w_marker || (in_valid && !w_full_after);
  assign w_drop       = in_valid && (w_marker || w_full_after);
  assign w_wdata      = w_marker ? {MARKER_TAG, r_drop_count} : in_data;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_level         <= '0;
      r_drop_count    <= 16'h0000;
      r_overflow_seen <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_level <= r_level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
      // A word arriving alongside a marker write is dropped and starts a new count.
      if (w_marker) begin
        r_drop_count <= in_valid ? 16'h0001 : 16'h0000;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'h0001;
      end
      if (w_drop) begin
        r_overflow_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_transmit <= 1'b0;
      r_tx_data  <= 24'h000000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_transmit <= 1'b0;
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_transmit <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_transmit <= 1'b0;
          r_state    <= ST_HOLD;
        end
        // The UART's tx_empty lags by a cycle; skipping it here avoids a double handoff.
        ST_HOLD: begin
          r_transmit <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_transmit <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign transmit      = r_transmit;
  assign tx_data       = r_tx_data;
  assign fifo_level    = r_level;
  assign overflow_seen = r_overflow_seen;
  assign drop_count    = r_drop_count;

endmodule
`default_nettype wire
